// File: rtl/asym_fifo_pkg.sv
// Shared types, helpers and the parameter-legality check for the asymmetric FIFO controller.

`ifndef ASYM_FIFO_PKG_SV
`define ASYM_FIFO_PKG_SV

// Rejects widths/depths that do not describe one RAM seen through two power-of-two aspect ratios.
`define ASYM_FIFO_CHECK_PARAMS(wa, da, wb, db) \
  if (((wb) % (wa)) != 0 || ((db) * ((wb) / (wa))) != (da) || \
      ((da) & ((da) - 1)) != 0 || \
      (((wb) / (wa)) & (((wb) / (wa)) - 1)) != 0) begin : g_param_check \
    $error("asym_fifo_ctrl: illegal WIDTH_A/DEPTH_A/WIDTH_B/DEPTH_B combination"); \
  end

package asym_fifo_pkg;

  // Occupancy of the output skid; encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // log2 of the wide/narrow width ratio (ratio assumed to be a power of two).
  function automatic int unsigned ratio_log2(input int unsigned width_a,
                                             input int unsigned width_b);
    int unsigned ratio;
    int unsigned lg;
    ratio = width_b / width_a;
    lg    = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < ratio) lg = i + 1;
    end
    return lg;
  endfunction

endpackage

`endif

// File: rtl/asym_fifo_skid.sv
// Two-entry output buffer for wide words; head entry drives the registered output.

module asym_fifo_skid
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output skid_state_t      occ,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  // State and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next occupancy and entry contents; push+pop holds the occupancy.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (clear) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = push_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = push_data;
          end else if (push) begin
            tail_d  = push_data;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d = tail_q;
            if (push) tail_d = push_data;
            else      state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign occ   = state_q;
  assign valid = (state_q != EMPTY);
  assign data  = head_q;

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Single-clock FIFO controller around an asymmetric dual-port RAM: narrow writes on port A,
// wide reads on port B, with a two-entry skid hiding the RAM read latency.
// Optional feature: define ASYM_FIFO_FLUSH_EN to add a synchronous flush input.

module asym_fifo_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WIDTH_A = 4,
  parameter int unsigned DEPTH_A = 1024,
  parameter int unsigned WIDTH_B = 16,
  parameter int unsigned DEPTH_B = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef ASYM_FIFO_FLUSH_EN
  input  logic                       flush,
`endif
  output logic [WIDTH_B-1:0]         out_data,
  output logic                       ram_ena,
  output logic                       ram_wea,
  output logic [$clog2(DEPTH_A)-1:0] ram_addra,
  output logic [WIDTH_A-1:0]         ram_dina,
  output logic                       ram_enb,
  output logic                       ram_web,
  output logic [$clog2(DEPTH_B)-1:0] ram_addrb,
  output logic [WIDTH_B-1:0]         ram_dinb,
  input  logic [WIDTH_B-1:0]         ram_doutb
);

  `ASYM_FIFO_CHECK_PARAMS(WIDTH_A, DEPTH_A, WIDTH_B, DEPTH_B)

  localparam int unsigned RatioLog2 = ratio_log2(WIDTH_A, WIDTH_B);
  localparam int unsigned Ratio     = 1 << RatioLog2;
  localparam int unsigned AwA       = $clog2(DEPTH_A);
  localparam int unsigned AwB       = $clog2(DEPTH_B);
  localparam int unsigned Cw        = AwA + 1;
  localparam logic [Cw-1:0] RatioCnt = Cw'(Ratio);
  localparam logic [Cw-1:0] DepthCnt = Cw'(DEPTH_A);

  logic [AwA-1:0] wr_ptr_q, wr_ptr_d;
  logic [AwB-1:0] rd_ptr_q, rd_ptr_d;
  logic [Cw-1:0]  count_q, count_d;
  logic           rd_pend_q, rd_pend_d;

  logic           flush_req;
  logic           full;
  logic           wr_fire;
  logic           pop;
  logic           rd_issue;
  logic [2:0]     credit;
  skid_state_t    skid_occ;
  logic [1:0]     skid_occ_num;

`ifdef ASYM_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign full     = (count_q == DepthCnt);
  assign in_ready = !full;
  assign wr_fire  = in_valid && in_ready && !flush_req;
  assign pop      = out_valid && out_ready;

  // Words already in the skid plus one in flight must leave room after this cycle's pop.
  assign skid_occ_num = skid_occ;
  assign credit       = {1'b0, skid_occ_num} + {2'b00, rd_pend_q};
  assign rd_issue     = !flush_req && (count_q >= RatioCnt) &&
                        (credit < (3'd2 + {2'b00, pop}));

  // Pointer, occupancy and read-pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next-state: space is released at read issue, not at pop; pointers wrap naturally.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AwA'(wr_fire);
    rd_ptr_d  = rd_ptr_q + AwB'(rd_issue);
    count_d   = count_q + Cw'(wr_fire) - (rd_issue ? RatioCnt : '0);
    rd_pend_d = rd_issue;
    if (flush_req) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_pend_d = 1'b0;
    end
  end

  asym_fifo_skid #(
    .WIDTH(WIDTH_B)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush_req),
    .push     (rd_pend_q),
    .push_data(ram_doutb),
    .pop      (pop),
    .occ      (skid_occ),
    .valid    (out_valid),
    .data     (out_data)
  );

  assign ram_ena   = wr_fire;
  assign ram_wea   = wr_fire;
  assign ram_addra = wr_ptr_q;
  assign ram_dina  = in_data;
  assign ram_enb   = rd_issue;
  assign ram_web   = 1'b0;
  assign ram_addrb = rd_ptr_q;
  assign ram_dinb  = '0;

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Directed bench for asym_fifo_ctrl with a behavioural asymmetric RAM (4-bit x16 / 16-bit x4).

module tb_asym_fifo_ctrl;

  localparam int unsigned WA = 4;
  localparam int unsigned DA = 16;
  localparam int unsigned WB = 16;
  localparam int unsigned DB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [WB-1:0] out_data;
  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [3:0]    ram_addra;
  logic [1:0]    ram_addrb;
  logic [WA-1:0] ram_dina;
  logic [WB-1:0] ram_dinb;
  logic [WB-1:0] ram_doutb;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  asym_fifo_ctrl #(
    .WIDTH_A(WA),
    .DEPTH_A(DA),
    .WIDTH_B(WB),
    .DEPTH_B(DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ASYM_FIFO_FLUSH_EN
    .flush    (flush),
`endif
    .out_data (out_data),
    .ram_ena  (ram_ena),
    .ram_wea  (ram_wea),
    .ram_addra(ram_addra),
    .ram_dina (ram_dina),
    .ram_enb  (ram_enb),
    .ram_web  (ram_web),
    .ram_addrb(ram_addrb),
    .ram_dinb (ram_dinb),
    .ram_doutb(ram_doutb)
  );

  // Behavioural RAM: narrow array, wide port reads RATIO consecutive narrow words, LSB first.
  logic [WA-1:0] mem [DA];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) begin
      for (int k = 0; k < 4; k++) ram_doutb[k*WA +: WA] <= mem[int'(ram_addrb) * 4 + k];
    end
  end

  // Output and read-issue monitors.
  logic [WB-1:0] got_q[$];
  int            enb_cnt = 0;
  always @(posedge clk) begin
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (ram_enb) enb_cnt++;
  end

  logic [WA-1:0] exp_n[$];
  int            got_head = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [WA-1:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Offer a word that must be accepted this cycle.
  task automatic put(input logic [WA-1:0] d, input logic r, input string tag);
    step(1'b1, d, r);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_ram_ena"}, 32'(ram_ena), 32'd1);
    exp_n.push_back(d);
  endtask

  // Pop everything complete and compare against the model built from accepted narrow words.
  task automatic drain(input string tag);
    int n;
    int waited;
    logic [WB-1:0] w;
    logic [WB-1:0] obs;
    n      = exp_n.size() / 4;
    waited = 0;
    while ((got_q.size() - got_head) < n && waited < 60) begin
      step(1'b0, '0, 1'b1);
      waited++;
    end
    check({tag, "_drain_in_time"}, 32'(waited < 60), 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) w[k*WA +: WA] = exp_n.pop_front();
      obs = (got_head < got_q.size()) ? got_q[got_head] : 'x;
      got_head++;
      check($sformatf("%s_word%0d", tag, i), 32'(obs), 32'(w));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check({tag, "_no_extra"}, 32'(got_q.size()), 32'(got_head));
    check({tag, "_out_valid_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ram_ena", 32'(ram_ena), 32'd0);
    check("rst_ram_enb", 32'(ram_enb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: four words -> 16'h4321, out_valid exactly 3 cycles after the 4th handshake
    put(4'h1, 1'b1, "t1_w0");
    check("t1_addra0", 32'(ram_addra), 32'd0);
    put(4'h2, 1'b1, "t1_w1");
    put(4'h3, 1'b1, "t1_w2");
    put(4'h4, 1'b1, "t1_w3");
    check("t1_addra3", 32'(ram_addra), 32'd3);
    check("t1_enb_before", 32'(ram_enb), 32'd0);
    step(1'b0, '0, 1'b1);
    check("t1_enb_t1", 32'(ram_enb), 32'd1);
    check("t1_addrb_t1", 32'(ram_addrb), 32'd0);
    check("t1_valid_t1", 32'(out_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    check("t1_valid_t2", 32'(out_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    check("t1_valid_t3", 32'(out_valid), 32'd1);
    check("t1_data_t3", 32'(out_data), 32'h4321);
    drain("t1");

    // 2: fill with reads blocked; two wide words move into the skid, so 24 words fit
    for (int i = 0; i < 24; i++) put(4'(i), 1'b0, $sformatf("t2_w%0d", i));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'hE, 1'b0);
      check($sformatf("t2_stall_rdy%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("t2_stall_ena%0d", i), 32'(ram_ena), 32'd0);
    end

    // 3: one pop frees a slot in the skid -> read issue that cycle, in_ready next cycle
    step(1'b0, '0, 1'b1);
    check("t3_pop_valid", 32'(out_valid), 32'd1);
    check("t3_pop_data", 32'(out_data), 32'h3210);
    check("t3_issue", 32'(ram_enb), 32'd1);
    check("t3_rdy_at_issue", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) put(4'(24 + i), 1'b0, $sformatf("t3_w%0d", i));
    step(1'b0, '0, 1'b0);
    check("t3_full_again", 32'(in_ready), 32'd0);
    drain("t3");

    // 4: partial residue is never emitted until completed
    put(4'h1, 1'b1, "t4_w0");
    put(4'h2, 1'b1, "t4_w1");
    put(4'h3, 1'b1, "t4_w2");
    e0 = enb_cnt;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    check("t4_no_enb", 32'(enb_cnt - e0), 32'd0);
    check("t4_no_valid", 32'(out_valid), 32'd0);
    check("t4_no_output", 32'(got_q.size()), 32'(got_head));
    put(4'hA, 1'b1, "t4_w3");
    drain("t4");

    // 5: continuous writes with toggling out_ready across several pointer wraps
    for (int i = 0; i < 40; i++) put(4'((i * 7 + 3) & 15), 1'(i % 2), $sformatf("t5_w%0d", i));
    drain("t5");

    // 6: reset mid-stream discards skid and residue; next sequence starts at lane 0
    for (int i = 0; i < 6; i++) put(4'(9 + i), 1'b0, $sformatf("t6_pre%0d", i));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    check("t6_valid_pre", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd1);
    check("t6_rst_enb", 32'(ram_enb), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_n.delete();
    got_head = got_q.size();
    put(4'h5, 1'b1, "t6_w0");
    check("t6_addra0", 32'(ram_addra), 32'd0);
    put(4'h6, 1'b1, "t6_w1");
    put(4'h7, 1'b1, "t6_w2");
    put(4'h8, 1'b1, "t6_w3");
    drain("t6");
    check("t6_lane0_word", 32'(got_q[got_q.size() - 1]), 32'h8765);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
